// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : 640x480@60 VGA pixel-timing generator: pixel enable, scan
//               counters, registered sync/video_on, and a per-frame refr_tick.
//               Build option VGA_SYNC_DELAY_EN delays hsync/vsync by one pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int TICK_DIV  = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       refr_tick
);

    localparam int c_div_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [9:0] c_h_last     = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_v_last     = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] c_h_disp     = 10'(H_DISPLAY);
    localparam logic [9:0] c_v_disp     = 10'(V_DISPLAY);
    localparam logic [9:0] c_v_disp_end = 10'(V_DISPLAY - 1);
    localparam logic [9:0] c_hs_start   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_hs_end     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_vs_start   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_vs_end     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic       w_p_tick;
    logic       w_h_end;
    logic       w_v_end;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;

    logic [9:0] r_pix_x;
    logic [9:0] r_pix_y;
    logic       r_video_on;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_refr_tick;

    generate
        if (TICK_DIV > 1) begin : g_div_multi
            logic [c_div_w-1:0] r_div_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_div_cnt <= '0;
                end else if (r_div_cnt == c_div_w'(TICK_DIV - 1)) begin
                    r_div_cnt <= '0;
                end else begin
                    r_div_cnt <= r_div_cnt + c_div_w'(1);
                end
            end

            assign w_p_tick = (r_div_cnt == c_div_w'(TICK_DIV - 1));
        end else begin : g_div_single
            assign w_p_tick = 1'b1;
        end
    endgenerate

    assign w_h_end  = (r_pix_x == c_h_last);
    assign w_v_end  = (r_pix_y == c_v_last);
    assign w_x_next = !w_p_tick ? r_pix_x :
                      (w_h_end ? 10'd0 : r_pix_x + 10'd1);
    assign w_y_next = !(w_p_tick && w_h_end) ? r_pix_y :
                      (w_v_end ? 10'd0 : r_pix_y + 10'd1);

    // Decode from the next counter values so the registered flags line up
    // with the coordinates they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_x     <= 10'd0;
            r_pix_y     <= 10'd0;
            r_video_on  <= 1'b1;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_refr_tick <= 1'b0;
        end else begin
            r_pix_x     <= w_x_next;
            r_pix_y     <= w_y_next;
            r_video_on  <= (w_x_next < c_h_disp) && (w_y_next < c_v_disp);
            r_hsync     <= !((w_x_next >= c_hs_start) && (w_x_next <= c_hs_end));
            r_vsync     <= !((w_y_next >= c_vs_start) && (w_y_next <= c_vs_end));
            r_refr_tick <= w_p_tick && w_h_end && (r_pix_y == c_v_disp_end);
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic r_hsync_d;
    logic r_vsync_d;

    // One-pixel lag to match a graphics stage that registers its RGB output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsync_d <= 1'b1;
            r_vsync_d <= 1'b1;
        end else if (w_p_tick) begin
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
        end
    end

    assign hsync = r_hsync_d;
    assign vsync = r_vsync_d;
`else
    assign hsync = r_hsync;
    assign vsync = r_vsync;
`endif

    assign p_tick    = w_p_tick;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign video_on  = r_video_on;
    assign refr_tick = r_refr_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen; expected outputs come
//               from a closed-form model of the scan position vs. clk count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam bit c_delay = 1'b1;
`else
    localparam bit c_delay = 1'b0;
`endif

    // Reduced geometry keeps several whole frames within a short run.
    localparam int c_hd = 20, c_hf = 4, c_hs = 6, c_hb = 5;
    localparam int c_vd = 12, c_vf = 2, c_vs = 2, c_vb = 3;
    localparam int c_frame_s = (c_hd + c_hf + c_hs + c_hb) * (c_vd + c_vf + c_vs + c_vb) * 2;

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       rt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic       s_pt, s_vo, s_hs, s_vs, s_rt;
    logic [9:0] s_x, s_y;
    logic       o_pt, o_vo, o_hs, o_vs, o_rt;
    logic [9:0] o_x, o_y;
    logic       d_pt, d_vo, d_hs, d_vs, d_rt;
    logic [9:0] d_x, d_y;

    int n_checks = 0;
    int n_errors = 0;
    int n = 0;
    int cyc = 0;
    bit track = 1'b0;
    int refr_at[$];
    int def_hs_low = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .TICK_DIV(2), .H_DISPLAY(c_hd), .H_FRONT(c_hf), .H_SYNC(c_hs), .H_BACK(c_hb),
        .V_DISPLAY(c_vd), .V_FRONT(c_vf), .V_SYNC(c_vs), .V_BACK(c_vb)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(s_pt), .pix_x(s_x), .pix_y(s_y),
        .video_on(s_vo), .hsync(s_hs), .vsync(s_vs), .refr_tick(s_rt)
    );

    vga_sync_gen #(
        .TICK_DIV(1), .H_DISPLAY(c_hd), .H_FRONT(c_hf), .H_SYNC(c_hs), .H_BACK(c_hb),
        .V_DISPLAY(c_vd), .V_FRONT(c_vf), .V_SYNC(c_vs), .V_BACK(c_vb)
    ) dut_d1 (
        .clk(clk), .reset(reset), .p_tick(o_pt), .pix_x(o_x), .pix_y(o_y),
        .video_on(o_vo), .hsync(o_hs), .vsync(o_vs), .refr_tick(o_rt)
    );

    vga_sync_gen dut_def (
        .clk(clk), .reset(reset), .p_tick(d_pt), .pix_x(d_x), .pix_y(d_y),
        .video_on(d_vo), .hsync(d_hs), .vsync(d_vs), .refr_tick(d_rt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // After n clk edges out of reset, the scan has advanced floor(n/d) pixels.
    function automatic exp_t model(input int nn, input int d, input int hd, input int hf,
                                   input int hsw, input int hb, input int vd, input int vf,
                                   input int vsw, input int vb);
        exp_t e;
        int ht, vt, k, x, y, ks, xs, ys;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        k  = nn / d;
        x  = k % ht;
        y  = (k / ht) % vt;
        e.pt = ((nn % d) == d - 1);
        e.x  = 10'(x);
        e.y  = 10'(y);
        e.vo = (x < hd) && (y < vd);
        ks = c_delay ? k - 1 : k;
        if (ks < 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            xs = ks % ht;
            ys = (ks / ht) % vt;
            e.hs = !((xs >= hd + hf) && (xs < hd + hf + hsw));
            e.vs = !((ys >= vd + vf) && (ys < vd + vf + vsw));
        end
        e.rt = (nn > 0) && ((nn % d) == 0) && ((k % (ht * vt)) == vd * ht);
        return e;
    endfunction

    task automatic check_inst(input string nm, input exp_t e, input logic pt,
                              input logic [9:0] x, input logic [9:0] y, input logic vo,
                              input logic hs, input logic vs, input logic rt);
        check({nm, ".p_tick"},    int'(pt), int'(e.pt));
        check({nm, ".pix_x"},     int'(x),  int'(e.x));
        check({nm, ".pix_y"},     int'(y),  int'(e.y));
        check({nm, ".video_on"},  int'(vo), int'(e.vo));
        check({nm, ".hsync"},     int'(hs), int'(e.hs));
        check({nm, ".vsync"},     int'(vs), int'(e.vs));
        check({nm, ".refr_tick"}, int'(rt), int'(e.rt));
    endtask

    task automatic check_all();
        check_inst("small", model(n, 2, c_hd, c_hf, c_hs, c_hb, c_vd, c_vf, c_vs, c_vb),
                   s_pt, s_x, s_y, s_vo, s_hs, s_vs, s_rt);
        check_inst("div1", model(n, 1, c_hd, c_hf, c_hs, c_hb, c_vd, c_vf, c_vs, c_vb),
                   o_pt, o_x, o_y, o_vo, o_hs, o_vs, o_rt);
        check_inst("def", model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33),
                   d_pt, d_x, d_y, d_vo, d_hs, d_vs, d_rt);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) n++;
        cyc++;
        @(negedge clk);
        if (track) begin
            if (s_rt) refr_at.push_back(cyc);
            if (!d_hs) def_hs_low++;
        end
        check_all();
    endtask

    initial begin
        int start;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n = 0;
        check_all();
        reset = 1'b1;
        start = cyc;

        track = 1'b1;
        repeat (3 * c_frame_s + 10) step();
        track = 1'b0;

        check("refr_count", refr_at.size(), 3);
        if (refr_at.size() > 0)
            check("refr_first", refr_at[0] - start, c_vd * (c_hd + c_hf + c_hs + c_hb) * 2);
        for (int i = 1; i < refr_at.size(); i++)
            check("refr_gap", refr_at[i] - refr_at[i-1], c_frame_s);
        // Two full default lines elapsed: 96 sync pixels x 2 clks each.
        check("def_hsync_low_clks", def_hs_low, 2 * 96 * 2);

        repeat (6) begin
            repeat ($urandom_range(50, 1500)) step();
            @(posedge clk);
            n++;
            cyc++;
            #2;
            reset = 1'b0;
            #1;
            n = 0;
            check_all();
            repeat ($urandom_range(1, 4)) step();
            reset = 1'b1;
        end

        repeat (200) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
